// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam int LATENCY_DEFAULT = 2;
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// Access-latency counter: loads 1 on grant, counts while busy, flags the last busy cycle.
module mem_lat_counter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  output logic last
);

  logic [CNT_W-1:0] count;

  assign last = (count == CNT_W'(LATENCY));

  // Clears itself on the final cycle so it idles at 0 between accesses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(1);
    end else if (run) begin
      if (last) count <= '0;
      else      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction port and a data port onto one single-port memory.
// Define ARB_RR_EN for round-robin on contention; default is fixed D-over-I priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEFAULT,
  parameter int WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_ready,
  output logic [WIDTH-1:0] i_data,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_ready,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic [1:0]       state
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_BUSY_I = BUSY_I;
  localparam logic [1:0] S_BUSY_D = BUSY_D;

  // Handshake: a requester raises req with its payload and holds both until its
  // ready pulses for one cycle; payload is captured at grant, and a requester is
  // not re-granted in the cycle its ready is high.
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] addr_q, wdata_q;
  logic             we_q;
  logic             i_elig, d_elig, pick_d, grant, last;

  assign i_elig = i_req && !i_ready;
  assign d_elig = d_req && !d_ready;
  assign grant  = (state_q == S_IDLE) && (i_elig || d_elig);

`ifdef ARB_RR_EN
  logic last_d;
  assign pick_d = d_elig && (!i_elig || !last_d);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   last_d <= 1'b0;
    else if (grant) last_d <= pick_d;
  end
`else
  assign pick_d = d_elig;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pick_d)      state_d = S_BUSY_D;
        else if (i_elig) state_d = S_BUSY_I;
      end
      S_BUSY_I, S_BUSY_D: begin
        if (last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_data  <= '0;
      d_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        addr_q  <= pick_d ? d_addr : i_addr;
        wdata_q <= pick_d ? d_wdata : '0;
        we_q    <= pick_d && d_we;
      end
      i_ready <= (state_q == S_BUSY_I) && last;
      d_ready <= (state_q == S_BUSY_D) && last;
      if ((state_q == S_BUSY_I) && last) i_data <= mem_rdata;
      // Stores complete with a pulse but leave the last load result intact.
      if ((state_q == S_BUSY_D) && last && !we_q) d_rdata <= mem_rdata;
    end
  end

  mem_lat_counter #(.LATENCY(LATENCY)) u_lat (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (grant),
    .run     (busy),
    .last    (last)
  );

  assign state     = state_q;
  assign busy      = (state_q != S_IDLE);
  assign mem_read  = (state_q == S_BUSY_I) || ((state_q == S_BUSY_D) && !we_q);
  assign mem_write = (state_q == S_BUSY_D) && we_q;
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_wdata = busy ? wdata_q : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 2, memory cycles per access, legal range 1..15.
REQ-002 Parameter WIDTH, default 16, data/address width.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_req  in  1  fetch request, held with i_addr until i_ready.
REQ-006 i_addr  in  WIDTH  fetch address.
REQ-007 i_ready  out  1  one-cycle pulse, i_data valid.
REQ-008 i_data  out  WIDTH  fetched word, registered.
REQ-009 d_req  in  1  data request, held with d_we/d_addr/d_wdata until d_ready.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_addr  in  WIDTH  data address.
REQ-012 d_wdata  in  WIDTH  store data.
REQ-013 d_ready  out  1  one-cycle pulse, access complete.
REQ-014 d_rdata  out  WIDTH  load data, registered, unchanged by stores.
REQ-015 mem_read / mem_write  out  1 each  single-port memory strobes.
REQ-016 mem_addr / mem_wdata  out  WIDTH each  memory address / write data.
REQ-017 mem_rdata  in  WIDTH  memory read data, valid in the last BUSY cycle.
REQ-018 busy  out  1  high in any BUSY state.

Function
REQ-019 FSM states IDLE, BUSY_I, BUSY_D, encoded in a 2-bit state register.
REQ-020 In IDLE, the arbiter SHALL grant D over I when both are eligible (fixed priority).
REQ-021 A requester whose ready is high in the current cycle SHALL be ineligible for grant in that cycle.
REQ-022 On grant, the arbiter SHALL latch addr, we and wdata; later changes to the request inputs SHALL be ignored until completion.
REQ-023 During BUSY the arbiter SHALL drive mem_addr and mem_wdata from the latches; mem_read = (BUSY_I or (BUSY_D and not we)); mem_write = BUSY_D and we; outside BUSY all four SHALL be 0.
REQ-024 A 4-bit counter SHALL be 1 in the first BUSY cycle and increment each cycle; the cycle with count == LATENCY is the last BUSY cycle.
REQ-025 At the edge ending the last BUSY cycle, the arbiter SHALL capture mem_rdata into i_data (or d_rdata on loads), pulse the matching ready for exactly one cycle, and return to IDLE.
REQ-026 Latency: request seen in IDLE in cycle 0 gives ready in cycle LATENCY+1; peak throughput is one access per LATENCY+1 cycles.
REQ-027 A store SHALL pulse d_ready and SHALL NOT modify d_rdata.
REQ-028 No request pending in IDLE: the FSM SHALL stay in IDLE with all strobes low.

Reset
REQ-029 Asserting reset_n low SHALL immediately force IDLE, counter 0, i_ready = d_ready = 0, i_data = d_rdata = 0, all mem_* outputs 0, busy 0.
REQ-030 An access in flight at reset SHALL be abandoned, with no ready pulse after reset release.

Configuration
REQ-031 Macro ARB_RR_EN defined: contention in IDLE SHALL be granted to the requester not served last; the last-served flag resets to I, so the first contention goes to D.
REQ-032 ARB_RR_EN undefined: fixed D-over-I priority per REQ-020, with no last-served register.

Structure
REQ-033 The shared package SHALL hold the state enum typedef and the LATENCY default constant.
REQ-034 Sub-module mem_lat_counter (load/increment/compare-to-LATENCY) SHALL be the one sub-module; everything else is inline.

Verification
REQ-035 LATENCY=2, i_req=1 with i_addr=0x0010 and mem_rdata=0x1234 -> mem_read high in cycles 1-2, i_ready in cycle 3 with i_data=0x1234.
REQ-036 i_req and d_req both rise in cycle 0, d_we=0 -> D served first (d_ready cycle 3), I granted in cycle 3, i_ready in cycle 6.
REQ-037 Store with d_addr=0x0020 and d_wdata=0xBEEF -> mem_write high with those values for LATENCY cycles, d_ready pulses, d_rdata unchanged.
REQ-038 reset_n driven low in cycle 2 of BUSY_D -> all outputs 0 at once; no d_ready after release; a fresh i_req completes normally.
REQ-039 ARB_RR_EN defined, both requests held continuously -> grants alternate D, I, D, I; with ARB_RR_EN undefined, I is served only when d_req is low or D is ineligible.
REQ-040 LATENCY=1 -> exactly one BUSY cycle, ready in cycle 2, counter never exceeds 1.
